// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the iteration counter width helper.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   function automatic int cnt_width(input int width, input int bpc);
      return $clog2(width / bpc);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface muldiv_if #(parameter int WIDTH = 32) ();
   logic             start;
   logic [2:0]       op;
   logic             kill;
   logic [WIDTH-1:0] Rdata1;
   logic [WIDTH-1:0] Rdata2;
   logic             busy;
   logic             done;
   logic             dz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, kill, Rdata1, Rdata2,
      input  busy, done, dz, hi, lo
   );

   modport slave (
      input  start, op, kill, Rdata1, Rdata2,
      output busy, done, dz, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// Combinational datapath slice: BPC iterations of shift-add multiply or
// restoring divide on a {upper, lower} accumulator.
module muldiv_step #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic                 mode,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     opd_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [2*WIDTH-1:0] a;
   logic [WIDTH:0]     t;

   // Multiply: upper = partial product, lower = multiplier shifting out.
   // Divide:   upper = partial remainder, lower = dividend in / quotient out.
   always_comb begin
      a = acc_i;
      t = '0;
      for (int i = 0; i < BPC; i++) begin
         if (!mode) begin
            t = {1'b0, a[2*WIDTH-1:WIDTH]} + (a[0] ? {1'b0, opd_i} : '0);
            a = {t, a[WIDTH-1:1]};
         end else begin
            t = {a[2*WIDTH-1:WIDTH], a[WIDTH-1]};
            if (t >= {1'b0, opd_i}) begin
               t = t - {1'b0, opd_i};
               a = {t[WIDTH-1:0], a[WIDTH-2:0], 1'b1};
            end else begin
               a = {t[WIDTH-1:0], a[WIDTH-2:0], 1'b0};
            end
         end
      end
      acc_o = a;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operates on magnitudes; signs are recorded at start and applied in FIX.
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO write here
//   RUN   | retiring BPC bits per cycle, counter counts down to 0
//   FIX   | sign correction / divide-by-zero result, write hi/lo
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic   CLK,
   input  logic   RST,
   muldiv_if.slave bus
);

   localparam int N  = WIDTH / BPC;
   localparam int CW = cnt_width(WIDTH, BPC);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, step_acc, prod;
   logic [WIDTH-1:0]     opd_q, opd_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]     mag1, mag2, quo, rem;
   logic                 is_div_q, is_div_d, dzop_q, dzop_d;
   logic                 neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic                 busy_q, busy_d, done_q, done_d, dz_q, dz_d;
   logic                 is_signed, is_div_op, accept;

   muldiv_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
      .mode  (is_div_q),
      .acc_i (acc_q),
      .opd_i (opd_q),
      .acc_o (step_acc)
   );

   always_comb begin
      is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
      mag1      = (is_signed && bus.Rdata1[WIDTH-1]) ? -bus.Rdata1 : bus.Rdata1;
      mag2      = (is_signed && bus.Rdata2[WIDTH-1]) ? -bus.Rdata2 : bus.Rdata2;
      accept    = (state_q == IDLE) && bus.start && !bus.kill;
      prod      = neg_lo_q ? -acc_q : acc_q;
      quo       = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem       = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      dzop_d   = dzop_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (bus.op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     is_div_d = is_div_op;
                     neg_lo_d = is_signed && (bus.Rdata1[WIDTH-1] ^ bus.Rdata2[WIDTH-1]);
                     neg_hi_d = is_signed && bus.Rdata1[WIDTH-1];
                     dz_d     = 1'b0;
                     cnt_d    = CW'(N - 1);
                     if (is_div_op) begin
                        acc_d = {{WIDTH{1'b0}}, mag1};
                        opd_d = mag2;
                     end else begin
                        acc_d = {{WIDTH{1'b0}}, mag2};
                        opd_d = mag1;
                     end
                     // A zero divisor skips iteration; keep raw rs for hi.
                     if (is_div_op && (bus.Rdata2 == '0)) begin
                        state_d = FIX;
                        dzop_d  = 1'b1;
                        acc_d   = {{WIDTH{1'b0}}, bus.Rdata1};
                     end else begin
                        state_d = RUN;
                        dzop_d  = 1'b0;
                     end
                  end
                  OP_MTHI: hi_d = bus.Rdata1;
                  OP_MTLO: lo_d = bus.Rdata1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (bus.kill) begin
               state_d = IDLE;
            end else begin
               acc_d = step_acc;
               if (cnt_q == '0) state_d = FIX;
               else             cnt_d   = cnt_q - CW'(1);
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!bus.kill) begin
               done_d = 1'b1;
               if (dzop_q) begin
                  hi_d = acc_q[WIDTH-1:0];
                  lo_d = '1;
                  dz_d = 1'b1;
               end else if (is_div_q) begin
                  hi_d = rem;
                  lo_d = quo;
               end else begin
                  {hi_d, lo_d} = prod;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         dzop_q   <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         dzop_q   <= dzop_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.dz   = dz_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level behavioural model on the BPC=1 instance
// plus directed literal checks on both BPC=1 and BPC=4 instances.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W  = 32;
   localparam int N1 = 32;
   localparam int N4 = 8;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   muldiv_if #(.WIDTH(W)) bus1 ();
   muldiv_if #(.WIDTH(W)) bus4 ();

   muldiv_unit #(.WIDTH(W), .BPC(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
   muldiv_unit #(.WIDTH(W), .BPC(4)) dut4 (.CLK(CLK), .RST(RST), .bus(bus4));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of one operation, from plain arithmetic.
   function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
      longint          sp;
      longint unsigned up;
      int              sa, sb;
      z = 1'b0; h = '0; l = '0;
      case (op)
         3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); {h, l} = sp; end
         3'd1: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
         3'd2, 3'd3: begin
            if (b == 0) begin h = a; l = '1; z = 1'b1; end
            else if (op == 3'd3) begin l = a / b; h = a % b; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = '0; end
            else begin sa = a; sb = b; l = sa / sb; h = sa % sb; end
         end
         default: ;
      endcase
   endfunction

   // Cycle-level model of dut1 driven purely by the handshake timing rules.
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        m_busy, m_done, m_dz, p_dz;
   int          m_left;
   bit          cmp_en = 0;

   always @(posedge CLK) begin
      m_done = 1'b0;
      if (RST) begin
         m_hi = '0; m_lo = '0; m_dz = 1'b0; m_busy = 1'b0; m_left = 0;
      end else if (m_busy) begin
         if (bus1.kill) m_busy = 1'b0;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0; m_done = 1'b1;
               m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
            end
         end
      end else if (bus1.start && !bus1.kill) begin
         case (bus1.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
               ref_op(bus1.op, bus1.Rdata1, bus1.Rdata2, p_hi, p_lo, p_dz);
               m_dz   = 1'b0;
               m_busy = 1'b1;
               m_left = p_dz ? 1 : N1 + 1;
            end
            3'd4: m_hi = bus1.Rdata1;
            3'd5: m_lo = bus1.Rdata1;
            default: ;
         endcase
      end
      cmp_en = 1;
   end

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("model busy", bus1.busy, m_busy);
         chk("model done", bus1.done, m_done);
         chk("model dz",   bus1.dz,   m_dz);
         chk("model hi",   bus1.hi,   m_hi);
         chk("model lo",   bus1.lo,   m_lo);
      end
   end

   task automatic issue1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus1.start = 1'b1; bus1.op = op; bus1.Rdata1 = a; bus1.Rdata2 = b;
      @(posedge CLK); #1;
      bus1.start = 1'b0;
   endtask

   task automatic issue4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus4.start = 1'b1; bus4.op = op; bus4.Rdata1 = a; bus4.Rdata2 = b;
      @(posedge CLK); #1;
      bus4.start = 1'b0;
   endtask

   // Called in cycle c0 after the start edge; returns in the done cycle.
   task automatic wait1(input string name, input int c0, input int exp_cyc, output int bcnt);
      int c = c0;
      bcnt = 0;
      while (!bus1.done && c < 200) begin
         if (bus1.busy) bcnt++;
         @(posedge CLK); #1; c++;
      end
      chk({name, " latency"}, c, exp_cyc);
   endtask

   task automatic wait4(input string name, input int exp_cyc);
      int c = 1;
      while (!bus4.done && c < 200) begin
         @(posedge CLK); #1; c++;
      end
      chk({name, " latency"}, c, exp_cyc);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h1;
         4: return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          bc, nd;
      logic [31:0] eh, el;
      logic        ez;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      bus1.start = 0; bus1.op = 0; bus1.kill = 0; bus1.Rdata1 = 0; bus1.Rdata2 = 0;
      bus4.start = 0; bus4.op = 0; bus4.kill = 0; bus4.Rdata1 = 0; bus4.Rdata2 = 0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset hi", bus1.hi, 0);     chk("reset lo", bus1.lo, 0);
      chk("reset busy", bus1.busy, 0); chk("reset done", bus1.done, 0);
      chk("reset dz", bus1.dz, 0);
      RST = 1'b0;
      @(posedge CLK); #1;

      issue1(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      wait1("mult", 1, 34, bc);
      chk("mult busy cycles", bc, 33);
      chk("mult hi", bus1.hi, 32'hFFFF_FFFF); chk("mult lo", bus1.lo, 32'hFFFF_FFF1);
      @(posedge CLK); #1;
      chk("mult done pulse", bus1.done, 0);

      issue1(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait1("multu", 1, 34, bc);
      chk("multu hi", bus1.hi, 32'hFFFF_FFFE); chk("multu lo", bus1.lo, 32'h1);

      issue1(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait1("div", 1, 34, bc);
      chk("div lo", bus1.lo, 32'hFFFF_FFFD); chk("div hi", bus1.hi, 32'hFFFF_FFFF);

      issue1(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait1("div ovf", 1, 34, bc);
      chk("div ovf lo", bus1.lo, 32'h8000_0000); chk("div ovf hi", bus1.hi, 0);
      chk("div ovf dz", bus1.dz, 0);

      issue1(OP_DIVU, 32'h1234, 32'h0);
      wait1("divu dz", 1, 2, bc);
      chk("dz hi", bus1.hi, 32'h1234); chk("dz lo", bus1.lo, 32'hFFFF_FFFF);
      chk("dz flag", bus1.dz, 1);
      issue1(OP_MULTU, 32'd3, 32'd4);
      chk("dz cleared", bus1.dz, 0);
      wait1("multu2", 1, 34, bc);
      chk("multu2 lo", bus1.lo, 32'd12);

      issue1(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
      chk("mthi", bus1.hi, 32'hA5A5_A5A5);
      issue1(OP_MULT, 32'd7, 32'd9);
      repeat (9) begin @(posedge CLK); #1; end
      bus1.kill = 1'b1;
      @(posedge CLK); #1;
      bus1.kill = 1'b0;
      chk("kill busy", bus1.busy, 0);
      nd = 0;
      repeat (40) begin if (bus1.done) nd++; @(posedge CLK); #1; end
      chk("kill no done", nd, 0);
      chk("kill hi kept", bus1.hi, 32'hA5A5_A5A5);

      issue1(OP_MTLO, 32'h77, 32'h0);
      chk("mtlo", bus1.lo, 32'h77);
      issue1(OP_MULT, 32'd2, 32'd3);
      issue1(OP_MTLO, 32'h55, 32'h0);
      chk("mtlo while busy", bus1.lo, 32'h77);
      wait1("mult3", 2, 34, bc);
      chk("mult3 lo", bus1.lo, 32'd6);

      issue1(OP_MULTU, 32'd6, 32'd7);
      wait1("b2b first", 1, 34, bc);
      issue1(OP_DIVU, 32'd100, 32'd7);
      chk("b2b done low", bus1.done, 0); chk("b2b busy", bus1.busy, 1);
      wait1("b2b second", 1, 34, bc);
      chk("b2b lo", bus1.lo, 32'd14); chk("b2b hi", bus1.hi, 32'd2);

      issue1(OP_DIV, 32'd1000, 32'd3);
      repeat (4) begin @(posedge CLK); #1; end
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("rst hi", bus1.hi, 0);     chk("rst lo", bus1.lo, 0);
      chk("rst busy", bus1.busy, 0); chk("rst done", bus1.done, 0);
      chk("rst dz", bus1.dz, 0);

      issue4(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait4("bpc4 multu", 10);
      chk("bpc4 hi", bus4.hi, 32'hFFFF_FFFE); chk("bpc4 lo", bus4.lo, 32'h1);
      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra = rnd_val(); rb = rnd_val();
         ref_op(rop, ra, rb, eh, el, ez);
         issue4(rop, ra, rb);
         wait4("bpc4 rnd", ez ? 2 : N4 + 2);
         chk("bpc4 rnd hi", bus4.hi, eh); chk("bpc4 rnd lo", bus4.lo, el);
         chk("bpc4 rnd dz", bus4.dz, ez);
      end

      for (int i = 0; i < 4000; i++) begin
         bus1.start  = ($urandom_range(0, 3) == 0);
         bus1.op     = 3'($urandom_range(0, 7));
         bus1.Rdata1 = rnd_val();
         bus1.Rdata2 = rnd_val();
         bus1.kill   = ($urandom_range(0, 63) == 0);
         RST         = ($urandom_range(0, 999) == 0);
         @(posedge CLK); #1;
      end
      bus1.start = 0; bus1.kill = 0; RST = 0;
      repeat (40) begin @(posedge CLK); #1; end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over several cycles with a start/busy/done handshake, replacing single-cycle combinational multiply/divide in the execute stage. It is parametrised in operand width and in bits retired per cycle, and it supports mid-operation cancellation for pipeline flushes.

## Interface
- WIDTH, 32, operand and HI/LO width; must be even and ≥ 8.
- BPC, 1, bits retired per RUN cycle; one of 1, 2, 4; WIDTH % BPC == 0.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  operation request; sampled only when busy=0.
- op  in  3  operation code, muldiv_pkg encoding.
- kill  in  1  abort the current operation or request.
- Rdata1  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- Rdata2  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- dz  out  1  last completed divide had divisor 0; valid from done until the next accepted start.
- hi  out  WIDTH  HI register; MFHI reads it directly.
- lo  out  WIDTH  LO register; MFLO reads it directly.

## Operation
- **States:** IDLE, RUN, FIX. Let N = WIDTH/BPC.
- **IDLE, start=1, kill=0:**
  - MULT, MULTU, DIV, DIVU: latch the operands and go to RUN with the iteration counter at N-1.
  - DIV or DIVU with Rdata2=0: go directly to FIX.
  - Signed ops: the operand magnitudes are latched, and the result sign bits are recorded.
- **MTHI / MTLO:** write hi (or lo) from Rdata1 at the sampling edge. No state change, no done, busy stays 0.
- **RUN:** retire BPC bits per cycle.
  - Multiply: shift-add into a 2×WIDTH accumulator.
  - Divide: restoring subtract-shift, producing the quotient and partial remainder.
  - Leave RUN when the counter reaches 0.
- **FIX:** apply sign correction, write hi/lo, then return to IDLE. done=1 on the following cycle.
- **Result rules:**
  - Multiply: {hi, lo} = full 2×WIDTH product; two's complement for MULT.
  - Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV of -2^(WIDTH-1) by -1: lo = -2^(WIDTH-1) (wraps), hi = 0. dz stays 0.
  - Divide by zero: hi = Rdata1, lo = all ones, dz = 1.
- **Ignored inputs:**
  - start while busy=1 is ignored. This includes MTHI/MTLO.
  - An undefined op code is ignored.
- **kill:**
  - In RUN or FIX: return to IDLE next cycle. hi, lo and dz are unchanged and no done is produced.
  - In IDLE: suppresses that cycle's start, including MTHI/MTLO.
- **Reset:** any state → IDLE. Reset values: hi=0, lo=0, busy=0, done=0, dz=0. Reset during RUN discards the operation.

## Timing
- Start accepted at edge 0 (cycle 0).
- busy=1 in cycles 1..N+1; the FIX state occupies cycle N+1.
- hi, lo, done=1 and busy=0 all appear in cycle N+2. Latency is N+2.
- Divide by zero: busy=1 in cycle 1 (FIX); done in cycle 2.
- A start in the done cycle is accepted (back-to-back operation). done is then 1 for exactly one cycle and busy rises the next cycle.
- MTHI/MTLO: the new value is visible in cycle 1.
- kill sampled at edge k: busy=0 from cycle k+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package muldiv_pkg holds:
  - op codes: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5;
  - the state encoding IDLE/RUN/FIX;
  - a function giving the counter width, clog2(WIDTH/BPC).
- Sub-module muldiv_step is purely combinational and is instantiated once.
  - Parameters: WIDTH, BPC. Input: a mode bit.
  - It performs BPC iterations of either shift-add or restoring-divide on the accumulator, the operand and the partial remainder.
- The top level owns the FSM, the counter, the sign bits and hi/lo/dz.

## Test plan
- **MULT:** WIDTH=32, BPC=1, MULT Rdata1=0xFFFFFFFD (-3), Rdata2=5 → done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high in cycles 1–33.
- **MULTU:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Repeat with BPC=4 → same result, done in cycle 10.
- **DIV, signed and overflow:**
  - DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, dz=0.
- **DIVU by zero:** DIVU 0x1234 / 0 → done in cycle 2, hi=0x1234, lo=0xFFFFFFFF, dz=1. A following MULTU start clears dz.
- **kill mid-RUN:** MTHI 0xA5A5A5A5, then MULT; kill at cycle 10 → busy=0 from cycle 11, no done pulse, hi=0xA5A5A5A5 unchanged.
- **Ignored and back-to-back starts:**
  - Start (MTLO 0x55) while busy → lo unchanged.
  - Start in the done cycle → accepted; second done N+2 cycles later.
  - RST asserted in cycle 5 of a divide → all outputs 0 in cycle 6.
